imem_boot: RTL and testbench
============================

# imem_boot

Parametrised, boot-loadable instruction memory for the CPU fetch stage. Generalises the fixed 16 × 32-bit flop IM to configurable width and depth. Adds:
- a streaming program-load port driven by a LOAD/RUN state machine;
- a registered fetch port with alignment and range fault reporting;
- a run-time reload request.

## Interface
Parameters:
- DATA_W, 32, instruction width in bits; power of two, ≥ 8.
- DEPTH, 16, number of instruction words; power of two, ≥ 2.
- PC_W, 32, fetch address width (byte address).
- FILL_WORD, 0, value every word takes on reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  reset, synchronous, active-high.
- load_valid  in  1  load word present.
- load_data  in  DATA_W  word to store at the current load pointer.
- load_last  in  1  marks the final word of the program; qualified by load_valid.
- load_ready  out  1  high in LOAD state.
- reload  in  1  one-cycle pulse in RUN that restarts loading.
- boot_done  out  1  high in RUN state.
- fetch_req  in  1  fetch request; sampled only in RUN.
- fetch_pc  in  PC_W  byte address of the instruction.
- fetch_valid  out  1  response strobe, one cycle after the accepted request.
- fetch_instr  out  DATA_W  instruction word; 0 when faulted.
- fetch_fault  out  1  misaligned or out-of-range fetch.

## Operation
- Derived constants:
  - OFF_W = log2(DATA_W/8).
  - IDX_W = log2(DEPTH).
  - idx = fetch_pc[OFF_W+IDX_W-1 : OFF_W].
- Storage is a DEPTH × DATA_W flop array. On reset every word = FILL_WORD.
- FSM states are LOAD and RUN. Reset enters LOAD with load pointer ptr = 0.
- LOAD state:
  - load_ready = 1, boot_done = 0.
  - On load_valid: mem[ptr] ← load_data and ptr ← ptr+1.
  - Go to RUN when the accepted word has load_last = 1, or when ptr == DEPTH-1 (the memory is full). Further words are never written past DEPTH-1.
  - Words not written keep their previous content.
- RUN state:
  - load_ready = 0, boot_done = 1.
  - load_valid is ignored; no memory write occurs.
  - reload = 1 sets ptr ← 0 and returns to LOAD. Memory is not cleared.
- Fetch in RUN:
  - An accepted request produces fetch_valid = 1 on the next cycle.
  - fetch_fault = 1 if fetch_pc[OFF_W-1:0] ≠ 0, or if any fetch_pc bit at or above OFF_W+IDX_W is 1.
  - fetch_instr = mem[idx] when there is no fault, else 0.
  - Back-to-back requests give back-to-back responses.
- fetch_req in LOAD is dropped: fetch_valid stays 0 the next cycle.
- Simultaneous reload and fetch_req in RUN: the fetch is served from the current contents (response next cycle) and the state becomes LOAD.
- Reset takes priority over all inputs, including mid-load and mid-fetch:
  - the memory is refilled with FILL_WORD;
  - ptr = 0 and state = LOAD;
  - any pending response is cancelled.

## Timing
- Output values during and after reset: load_ready = 1, boot_done = 0, fetch_valid = 0, fetch_instr = 0, fetch_fault = 0.
- Fetch latency is 1 cycle. Throughput is 1 fetch per cycle.
- All outputs are registered except load_ready and boot_done, which are decoded directly from the state register.
- A word is loaded in the same cycle as the load_valid && load_ready handshake; there is no back-pressure inside LOAD.
- The final load word is accepted in cycle N; boot_done = 1 in cycle N+1; a fetch issued in N+1 returns that word in N+2.
- fetch_valid, fetch_instr and fetch_fault hold for exactly one cycle per accepted request. They return to 0 when no request was accepted.

## Structure
- Shared package imem_pkg holds:
  - the state enum imem_state_t {ST_LOAD, ST_RUN};
  - the derived-width functions (OFF_W, IDX_W);
  - a fault-check function, reused by the data memory.
- One sub-module, imem_load_ctrl, contains the FSM and load pointer. Its outputs are write-enable, write index, load_ready and boot_done.
- The array, fetch decode and response register stay in the top level.

## Test plan
- Reset with defaults, then load 3 words 0xA1, 0xB2, 0xC3 with load_last on the third → boot_done = 1 the next cycle. Fetches at pc 0x0, 0x4, 0x8 return 0xA1, 0xB2, 0xC3, each 1 cycle later. Fetch at 0xC returns FILL_WORD (0).
- Load 16 words with load_last never asserted → RUN entered after word 15. A 17th load_valid is not written, so mem[0] is unchanged.
- In RUN, fetch pc 0x2 → fault = 1, instr = 0. Fetch pc 0x40 (idx overflow) → fault = 1. Fetch pc 0x3C → no fault, returns word 15.
- Back-to-back fetches 0x0, 0x4, 0x0 on 3 consecutive cycles → 3 consecutive valid responses in order. fetch_req while in LOAD → no fetch_valid.
- In RUN, pulse reload together with a fetch at 0x4 → 0xB2 returned next cycle and load_ready = 1. Reloading 0x55 → mem[0] = 0x55, and mem[1] still 0xB2 after load_last.
- Assert reset mid-load after 2 words → all outputs at reset values next cycle, fetches after a 1-word reload show words 1..15 = 0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the boot-loadable instruction memory: FSM states,
// derived address-field widths and the fetch address fault check.
package imem_pkg;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } imem_state_t;

    // Widest fetch address the fault check accepts; narrower PCs are zero-extended.
    localparam int FAULT_PC_W = 64;

    function automatic int off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

    // Any set bit below the word offset (misaligned) or above the index field
    // (outside the array) faults the access.
    function automatic logic addr_fault(input logic [FAULT_PC_W-1:0] pc,
                                        input int offw,
                                        input int idxw);
        logic f;
        f = 1'b0;
        for (int b = 0; b < FAULT_PC_W; b++) begin
            if (pc[b] && ((b < offw) || (b >= offw + idxw))) begin
                f = 1'b1;
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/imem_load_ctrl.sv
// LOAD/RUN state machine and load pointer for the instruction memory; issues
// one write per accepted load word and stops at the last word or when full.
module imem_load_ctrl import imem_pkg::*; #(
    parameter int DEPTH = 16,
    parameter int IDX_W = idx_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid_i,
    input  logic             load_last_i,
    input  logic             reload_i,
    output logic             we_o,
    output logic [IDX_W-1:0] widx_o,
    output logic             load_ready_o,
    output logic             boot_done_o
);

    imem_state_t      state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LOAD;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        we_o         = 1'b0;
        widx_o       = ptr_q;
        load_ready_o = 1'b0;
        boot_done_o  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                load_ready_o = 1'b1;
                if (load_valid_i) begin
                    we_o  = 1'b1;
                    ptr_d = ptr_q + IDX_W'(1);
                    // Leaving LOAD on the top word guarantees no write past DEPTH-1.
                    if (load_last_i || (ptr_q == IDX_W'(DEPTH - 1))) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                boot_done_o = 1'b1;
                if (reload_i) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_LOAD;
                ptr_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/imem_boot.sv
// Boot-loadable instruction memory: flop array filled through a streaming load
// port, then read through a registered fetch port with fault reporting.
module imem_boot import imem_pkg::*; #(
    parameter int              DATA_W    = 32,
    parameter int              DEPTH     = 16,
    parameter int              PC_W      = 32,
    parameter logic [DATA_W-1:0] FILL_WORD = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              reload,
    output logic              boot_done,
    input  logic              fetch_req,
    input  logic [PC_W-1:0]   fetch_pc,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_fault
);

    localparam int OFF_W = off_w(DATA_W);
    localparam int IDX_W = idx_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              we;
    logic [IDX_W-1:0]  widx;
    logic              accept;
    logic              fault;
    logic [IDX_W-1:0]  idx;

    logic              rsp_vld_q, rsp_vld_d;
    logic              rsp_fault_q, rsp_fault_d;
    logic [DATA_W-1:0] rsp_instr_q, rsp_instr_d;

    imem_load_ctrl #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_load_ctrl (
        .clk          (clk),
        .reset        (reset),
        .load_valid_i (load_valid),
        .load_last_i  (load_last),
        .reload_i     (reload),
        .we_o         (we),
        .widx_o       (widx),
        .load_ready_o (load_ready),
        .boot_done_o  (boot_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= FILL_WORD;
            end
        end else if (we) begin
            mem_q[widx] <= load_data;
        end
    end

    // Fetches are only honoured in RUN; a reload in the same cycle still sees
    // RUN here, so that request is served from the pre-reload contents.
    assign accept = fetch_req && boot_done;
    assign idx    = fetch_pc[OFF_W+IDX_W-1:OFF_W];
    assign fault  = addr_fault(FAULT_PC_W'(fetch_pc), OFF_W, IDX_W);

    always_comb begin
        rsp_vld_d   = accept;
        rsp_fault_d = accept && fault;
        rsp_instr_d = '0;
        if (accept && !fault) begin
            rsp_instr_d = mem_q[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_vld_q   <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_instr_q <= '0;
        end else begin
            rsp_vld_q   <= rsp_vld_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_instr_q <= rsp_instr_d;
        end
    end

    assign fetch_valid = rsp_vld_q;
    assign fetch_fault = rsp_fault_q;
    assign fetch_instr = rsp_instr_q;

endmodule

// File: tb/tb_imem_boot.sv
// Directed bench for imem_boot: an abstract memory/boot model is checked
// against the DUT every cycle, plus hand-computed spot values.
module tb_imem_boot;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        reload;
    logic        boot_done;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_fault;

    int n_chk  = 0;
    int n_fail = 0;

    imem_boot dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .reload      (reload),
        .boot_done   (boot_done),
        .fetch_req   (fetch_req),
        .fetch_pc    (fetch_pc),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    // Model: 16 words of 4 bytes, booted flag, next load slot.
    logic [31:0] m_mem [16];
    logic        m_run   = 1'b0;
    int          m_ptr   = 0;
    logic        e_vld   = 1'b0;
    logic        e_fault = 1'b0;
    logic [31:0] e_instr = '0;

    function automatic logic bad_pc(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc >= 64);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) m_mem[i] <= 32'h0;
            m_run   <= 1'b0;
            m_ptr   <= 0;
            e_vld   <= 1'b0;
            e_fault <= 1'b0;
            e_instr <= 32'h0;
        end else begin
            e_vld   <= m_run && fetch_req;
            e_fault <= m_run && fetch_req && bad_pc(fetch_pc);
            e_instr <= (m_run && fetch_req && !bad_pc(fetch_pc)) ? m_mem[fetch_pc / 4] : 32'h0;
            if (!m_run) begin
                if (load_valid) begin
                    m_mem[m_ptr] <= load_data;
                    m_ptr        <= m_ptr + 1;
                    if (load_last || m_ptr == 15) m_run <= 1'b1;
                end
            end else if (reload) begin
                m_run <= 1'b0;
                m_ptr <= 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model load_ready",  32'(load_ready),  32'(!m_run));
        check("model boot_done",   32'(boot_done),   32'(m_run));
        check("model fetch_valid", 32'(fetch_valid), 32'(e_vld));
        check("model fetch_fault", 32'(fetch_fault), 32'(e_fault));
        check("model fetch_instr", fetch_instr,      e_instr);
    end

    // Drive one cycle of inputs; returns after the following negedge, when
    // registered results of this cycle are visible.
    task automatic step(input logic rst, input logic lv, input logic [31:0] ld,
                        input logic ll, input logic rl, input logic fr,
                        input logic [31:0] pc);
        reset      = rst;
        load_valid = lv;
        load_data  = ld;
        load_last  = ll;
        reload     = rl;
        fetch_req  = fr;
        fetch_pc   = pc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic load(input logic [31:0] d, input logic last);
        step(0, 1, d, last, 0, 0, 0);
    endtask

    task automatic fetch(input logic [31:0] pc);
        step(0, 0, 0, 0, 0, 1, pc);
    endtask

    initial begin
        reset = 1'b1; load_valid = 0; load_data = 0; load_last = 0;
        reload = 0; fetch_req = 0; fetch_pc = 0;
        @(negedge clk);
        step(1, 0, 0, 0, 0, 1, 0);
        check("reset load_ready", 32'(load_ready), 32'd1);
        check("reset boot_done",  32'(boot_done),  32'd0);
        check("reset fetch_valid", 32'(fetch_valid), 32'd0);

        // Boot a 3-word program
        load(32'hA1, 0);
        load(32'hB2, 0);
        check("no boot before last", 32'(boot_done), 32'd0);
        load(32'hC3, 1);
        check("boot_done after last", 32'(boot_done), 32'd1);
        fetch(32'h0); check("fetch 0x0", fetch_instr, 32'hA1);
        fetch(32'h4); check("fetch 0x4", fetch_instr, 32'hB2);
        fetch(32'h8); check("fetch 0x8", fetch_instr, 32'hC3);
        fetch(32'hC); check("fetch 0xC fill", fetch_instr, 32'h0);
        check("fetch 0xC valid", 32'(fetch_valid), 32'd1);
        idle();
        check("valid drops", 32'(fetch_valid), 32'd0);

        // Faults and back-to-back
        fetch(32'h2);  check("misaligned fault", 32'(fetch_fault), 32'd1);
        check("misaligned instr", fetch_instr, 32'h0);
        fetch(32'h40); check("range fault", 32'(fetch_fault), 32'd1);
        fetch(32'h0);
        fetch(32'h4);  check("b2b second", fetch_instr, 32'hB2);
        fetch(32'h0);  check("b2b third", fetch_instr, 32'hA1);
        check("b2b third valid", 32'(fetch_valid), 32'd1);
        load(32'hDEAD, 1);
        check("load ignored in RUN", 32'(boot_done), 32'd1);

        // Reload together with a fetch
        step(0, 0, 0, 0, 1, 1, 32'h4);
        check("reload+fetch instr", fetch_instr, 32'hB2);
        check("reload load_ready", 32'(load_ready), 32'd1);
        fetch(32'h0);
        check("fetch in LOAD dropped", 32'(fetch_valid), 32'd0);
        load(32'h55, 1);
        fetch(32'h0); check("reloaded word0", fetch_instr, 32'h55);
        fetch(32'h4); check("kept word1", fetch_instr, 32'hB2);

        // Full 16-word load without load_last
        step(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 16; i++) load(32'h100 + 32'(i), 0);
        check("full -> RUN", 32'(boot_done), 32'd1);
        load(32'hBEEF, 0);
        fetch(32'h0);  check("no overwrite word0", fetch_instr, 32'h100);
        fetch(32'h3C); check("word15", fetch_instr, 32'h10F);
        check("word15 no fault", 32'(fetch_fault), 32'd0);

        // Reset mid-load and mid-fetch
        step(0, 0, 0, 0, 1, 0, 0);
        load(32'h11, 0);
        load(32'h22, 0);
        step(1, 1, 32'h33, 0, 0, 1, 32'h0);
        check("midreset load_ready", 32'(load_ready), 32'd1);
        check("midreset fetch_valid", 32'(fetch_valid), 32'd0);
        check("midreset fetch_instr", fetch_instr, 32'h0);
        load(32'h77, 1);
        fetch(32'h0); check("after reset word0", fetch_instr, 32'h77);
        for (int i = 1; i < 16; i++) begin
            fetch(32'(i * 4));
            check("after reset cleared word", fetch_instr, 32'h0);
        end
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
